axis_parity_demux: RTL and testbench
====================================

Name: axis_parity_demux

Overview:
Parametrised AXI-Stream demultiplexer that routes each input beat by the XOR-parity of its data. Even-parity beats go to the even output stream and odd-parity beats go to the odd output stream. Each output has its own FIFO and full tready/tvalid back-pressure. Each input packet is split into at most two output packets, each closed with a correct tlast. The block sits between an upstream byte/word source and two independent downstream consumers.

Parameters:
DATA_W, 8, data width in bits (>=1)
FIFO_DEPTH, 16, entries per output FIFO; power of 2, >=2
ODD_IS_ONE, 1, 1: odd = XOR of bits is 1; 0: swaps the routing of the two outputs

Ports:
a_clk  in  1  clock, all logic rising-edge
axis_aresetn  in  1  reset, asynchronous, active-low
s_axis_tdata  in  DATA_W  input beat data
s_axis_tvalid  in  1  input beat valid
s_axis_tlast  in  1  input end of packet
s_axis_tready  out  1  input accept
m_even_tdata  out  DATA_W  even stream data
m_even_tvalid  out  1  even stream valid
m_even_tlast  out  1  even stream end of packet
m_even_tready  in  1  even stream consumer ready
m_odd_tdata  out  DATA_W  odd stream data
m_odd_tvalid  out  1  odd stream valid
m_odd_tlast  out  1  odd stream end of packet
m_odd_tready  in  1  odd stream consumer ready

Behaviour:
- Reset: asynchronous assert, synchronous deassert use. All outputs are 0 during reset: s_axis_tready=0, all m_* valid/last/data=0. FIFOs are emptied, hold registers are invalidated, state=RUN.
- Parity: p = XOR-reduce(s_axis_tdata). Channel = odd if (p==ODD_IS_ONE), else even.
- Per channel there is a one-entry hold register (hold_v, hold_d). It provides the one-beat lookahead needed to place tlast.
- FSM states:
  - RUN: s_axis_tready = !even_full && !odd_full. tready never depends on tdata.
  - FLUSH: s_axis_tready = 0.
- Accepted beat (tvalid && tready) on channel c:
  - If hold_v[c], push {hold_d[c], tlast=0} into FIFO c.
  - Then hold_d[c] <= tdata and hold_v[c] <= 1.
  - If s_axis_tlast, next state = FLUSH.
- FLUSH, each cycle, per channel independently: if hold_v[c] and FIFO c is not full, push {hold_d[c], tlast=1} and clear hold_v[c]. Both channels may push in the same cycle. When both hold_v are 0, return to RUN.
- FLUSH lasts at least 1 cycle. It lasts longer only while a target FIFO is full.
- A channel with no beats in a packet emits nothing: empty output packets are suppressed.
- Latency:
  - A beat enters its FIFO when the next same-channel beat is accepted, or 1 cycle after tlast acceptance (when the FIFO has space).
  - FIFO output is first-word-fall-through. An entry written at cycle n is visible on m_*_tvalid at cycle n+1.
- Output handshake:
  - The entry is popped when m_*_tvalid && m_*_tready.
  - tdata, tvalid and tlast stay stable while tready=0.
  - tvalid never depends on tready.
- FIFO boundaries:
  - Push and pop in the same cycle when full: allowed. The push is accepted because the pop frees the slot.
  - Push when empty: visible next cycle. There is no combinational bypass.
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits, so full and empty are distinguished by the wrap bit.
- A beat in RUN without tlast never pushes more than one entry per channel per cycle.
- Reset mid-packet or mid-FLUSH: all state is discarded and partial packets are lost. No tlast is synthesised afterwards.

Decomposition:
- Package axis_parity_pkg holds:
  - state enum {RUN, FLUSH};
  - parity function parity_of(data);
  - localparam PTR_W = $clog2(FIFO_DEPTH)+1.
- Sub-module axis_sync_fifo (DATA_W+1 bits wide, FIFO_DEPTH deep, FWFT, full/empty outputs) is instantiated twice, once for even and once for odd.
- The top level holds the FSM, the hold registers and the routing logic.

Test Plan:
1. Packet 0x03,0x01,0x07,0x05(tlast), both tready=1:
   - even stream = 0x03,0x05(tlast);
   - odd stream = 0x01,0x07(tlast);
   - s_axis_tready drops for exactly 1 cycle after 0x05.
2. Packet of only even bytes 0x00,0x11,0x22(tlast):
   - even stream = 3 beats with tlast on 0x22;
   - odd stream never asserts tvalid.
3. Back-pressure with m_odd_tready=0 and 20 odd bytes in one packet at FIFO_DEPTH=16:
   - s_axis_tready goes 0 once 16 entries are queued;
   - releasing tready drains all 20 in order, tlast on the 20th;
   - no loss or duplication.
4. Single-beat packet 0x80(tlast): odd stream emits 0x80 with tlast=1 two cycles after acceptance.
5. Assert axis_aresetn=0 mid-packet after 0x01,0x03:
   - all outputs are 0 immediately;
   - after release, a new packet 0x06(tlast) yields only even 0x06(tlast).
6. Random tvalid and both treadys toggling over 1000 packets:
   - scoreboard confirms per-channel order, tlast once per non-empty sub-packet, and AXIS stability rules.

Source files
------------

// File: rtl/axis_parity_pkg.sv
// Shared types and helpers for the parity-routing AXI-Stream demultiplexer.
//   state_t     : top-level FSM states (RUN accepts beats, FLUSH closes sub-packets)
//   parity_of   : XOR-reduction of a beat, zero-extended to PARITY_MAX_W bits
//   PTR_W       : FIFO pointer width for the default depth (address bits + wrap bit)
package axis_parity_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_FIFO_DEPTH = 16;
    localparam int unsigned PTR_W              = $clog2(DEFAULT_FIFO_DEPTH) + 1;

    // Widest data bus parity_of handles; zero-extension leaves the XOR unchanged.
    localparam int unsigned PARITY_MAX_W = 256;

    function automatic logic parity_of(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   a_clk, axis_aresetn : clock, async active-low reset (empties the FIFO)
//   push, push_data     : write request; accepted when not full, or when full with a pop
//   full                : no free slot this cycle
//   pop                 : consume the head entry (ignored when empty)
//   pop_data            : head entry, forced to zero while empty
//   empty               : no entry visible
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic             a_clk,
    input  logic             axis_aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PW     = ADDR_W + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra wrap bit separates full from empty when the address bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

    // Pointer registers.
    always_ff @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage; contents are don't-care until the pointers expose them.
    always_ff @(posedge a_clk) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/axis_parity_demux.sv
// AXI-Stream demultiplexer routing each beat by the XOR-parity of its data.
// Each channel keeps one beat in a hold register so the last beat of a packet
// on that channel can be tagged with tlast once the input tlast is seen.
//   a_clk, axis_aresetn           : clock, async active-low reset
//   s_axis_t{data,valid,last,ready}: input stream
//   m_even_t{data,valid,last,ready}: even-parity output stream
//   m_odd_t{data,valid,last,ready} : odd-parity output stream
module axis_parity_demux
    import axis_parity_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ODD_IS_ONE = 1
) (
    input  logic              a_clk,
    input  logic              axis_aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_even_tdata,
    output logic              m_even_tvalid,
    output logic              m_even_tlast,
    input  logic              m_even_tready,
    output logic [DATA_W-1:0] m_odd_tdata,
    output logic              m_odd_tvalid,
    output logic              m_odd_tlast,
    input  logic              m_odd_tready
);

    localparam int unsigned ENTRY_W = DATA_W + 1;

    state_t              state;
    state_t              state_d;
    logic                live;
    logic                beat_odd;
    logic                accept_c;

    logic                even_hold_v;
    logic [DATA_W-1:0]   even_hold_d;
    logic                odd_hold_v;
    logic [DATA_W-1:0]   odd_hold_d;

    logic                even_push;
    logic                odd_push;
    logic [ENTRY_W-1:0]  even_wdata;
    logic [ENTRY_W-1:0]  odd_wdata;
    logic                even_full;
    logic                odd_full;
    logic                even_empty;
    logic                odd_empty;
    logic [ENTRY_W-1:0]  even_rdata;
    logic [ENTRY_W-1:0]  odd_rdata;

    assign beat_odd = (parity_of(PARITY_MAX_W'(s_axis_tdata)) == 1'(ODD_IS_ONE));

    // Keeps tready low during reset and for the first cycle after release.
    always_ff @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) live <= 1'b0;
        else               live <= 1'b1;
    end

    // State register.
    always_ff @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) state <= RUN;
        else               state <= state_d;
    end

    // Next state, input ready and FIFO write requests.
    always_comb begin
        state_d       = state;
        s_axis_tready = 1'b0;
        accept_c      = 1'b0;
        even_push     = 1'b0;
        odd_push      = 1'b0;
        even_wdata    = {1'b0, even_hold_d};
        odd_wdata     = {1'b0, odd_hold_d};
        case (state)
            RUN: begin
                s_axis_tready = live && !even_full && !odd_full;
                accept_c      = s_axis_tvalid && s_axis_tready;
                // A new beat retires the previous same-channel beat as a non-last entry.
                if (accept_c) begin
                    if (beat_odd) odd_push  = odd_hold_v;
                    else          even_push = even_hold_v;
                    if (s_axis_tlast) state_d = FLUSH;
                end
            end
            FLUSH: begin
                even_push  = even_hold_v && !even_full;
                odd_push   = odd_hold_v && !odd_full;
                even_wdata = {1'b1, even_hold_d};
                odd_wdata  = {1'b1, odd_hold_d};
                if ((!even_hold_v || even_push) && (!odd_hold_v || odd_push)) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Hold registers: loaded by accepted beats, cleared when flushed with tlast.
    always_ff @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            even_hold_v <= 1'b0;
            even_hold_d <= '0;
            odd_hold_v  <= 1'b0;
            odd_hold_d  <= '0;
        end else if (accept_c) begin
            if (beat_odd) begin
                odd_hold_v <= 1'b1;
                odd_hold_d <= s_axis_tdata;
            end else begin
                even_hold_v <= 1'b1;
                even_hold_d <= s_axis_tdata;
            end
        end else if (state == FLUSH) begin
            if (even_push) even_hold_v <= 1'b0;
            if (odd_push)  odd_hold_v  <= 1'b0;
        end
    end

    axis_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_even_fifo (
        .a_clk        (a_clk),
        .axis_aresetn (axis_aresetn),
        .push         (even_push),
        .push_data    (even_wdata),
        .full         (even_full),
        .pop          (m_even_tready),
        .pop_data     (even_rdata),
        .empty        (even_empty)
    );

    axis_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_odd_fifo (
        .a_clk        (a_clk),
        .axis_aresetn (axis_aresetn),
        .push         (odd_push),
        .push_data    (odd_wdata),
        .full         (odd_full),
        .pop          (m_odd_tready),
        .pop_data     (odd_rdata),
        .empty        (odd_empty)
    );

    assign m_even_tvalid                = !even_empty;
    assign {m_even_tlast, m_even_tdata} = even_rdata;
    assign m_odd_tvalid                 = !odd_empty;
    assign {m_odd_tlast, m_odd_tdata}   = odd_rdata;

endmodule

// File: tb/tb_axis_parity_demux.sv
// Scoreboard bench for axis_parity_demux (DATA_W=8, FIFO_DEPTH=16, ODD_IS_ONE=1).
module tb_axis_parity_demux;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 16;

    typedef struct packed {
        logic             last;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic              a_clk = 1'b0;
    logic              axis_aresetn = 1'b0;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tlast = 1'b0;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_even_tdata;
    logic              m_even_tvalid;
    logic              m_even_tlast;
    logic              m_even_tready;
    logic [DATA_W-1:0] m_odd_tdata;
    logic              m_odd_tvalid;
    logic              m_odd_tlast;
    logic              m_odd_tready;

    logic rand_rdy  = 1'b0;
    logic dir_e_rdy = 1'b1;
    logic dir_o_rdy = 1'b1;
    logic rnd_e     = 1'b1;
    logic rnd_o     = 1'b1;

    assign m_even_tready = rand_rdy ? rnd_e : dir_e_rdy;
    assign m_odd_tready  = rand_rdy ? rnd_o : dir_o_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t exp_even[$];
    beat_t exp_odd[$];

    axis_parity_demux #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ODD_IS_ONE (1)
    ) dut (
        .a_clk         (a_clk),
        .axis_aresetn  (axis_aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_even_tdata  (m_even_tdata),
        .m_even_tvalid (m_even_tvalid),
        .m_even_tlast  (m_even_tlast),
        .m_even_tready (m_even_tready),
        .m_odd_tdata   (m_odd_tdata),
        .m_odd_tvalid  (m_odd_tvalid),
        .m_odd_tlast   (m_odd_tlast),
        .m_odd_tready  (m_odd_tready)
    );

    always #5 a_clk = ~a_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-count based parity, independent of the DUT's XOR reduction.
    function automatic logic model_is_odd(input logic [DATA_W-1:0] d);
        int c = 0;
        for (int i = 0; i < int'(DATA_W); i++) c += int'(d[i]);
        return (c % 2) == 1;
    endfunction

    task automatic push_exp(input logic odd, input logic [DATA_W-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        if (odd) exp_odd.push_back(b);
        else     exp_even.push_back(b);
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic l);
        logic acc = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge a_clk);
            acc = s_axis_tready;
            @(posedge a_clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: beat %h never accepted", d);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge a_clk);
            #1;
        end
    endtask

    // Wait until every expected beat has been seen (bounded).
    task automatic drain();
        int k = 0;
        while ((exp_even.size() != 0 || exp_odd.size() != 0) && k < 4000) begin
            @(posedge a_clk);
            #1;
            k++;
        end
        idle(3);
        check("drain_pending", 32'(exp_even.size() + exp_odd.size()), 32'd0);
    endtask

    task automatic rand_packet();
        logic [DATA_W-1:0] d [6];
        int len    = int'($urandom_range(1, 6));
        int last_e = -1;
        int last_o = -1;
        for (int i = 0; i < len; i++) begin
            d[i] = DATA_W'($urandom);
            if (model_is_odd(d[i])) last_o = i;
            else                    last_e = i;
        end
        for (int i = 0; i < len; i++)
            push_exp(model_is_odd(d[i]), d[i], (i == last_o) || (i == last_e));
        for (int i = 0; i < len; i++) begin
            idle(int'($urandom_range(0, 2)));
            send_beat(d[i], i == len - 1);
        end
    endtask

    // Random consumer readiness for the soak phase.
    always @(posedge a_clk) begin
        #1;
        rnd_e = ($urandom_range(0, 3) != 0);
        rnd_o = ($urandom_range(0, 2) != 0);
    end

    // Even-stream monitor: order, tlast and hold-while-stalled checks.
    logic  e_pv = 1'b0;
    logic  e_pr = 1'b0;
    beat_t e_pd;
    beat_t e_exp;
    always @(negedge a_clk) begin
        if (!axis_aresetn) begin
            e_pv = 1'b0;
        end else begin
            if (e_pv && !e_pr)
                check("even_stable", 32'({m_even_tvalid, m_even_tlast, m_even_tdata}), 32'({1'b1, e_pd}));
            if (m_even_tvalid && m_even_tready) begin
                if (exp_even.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL even_unexpected: got last=%b data=%h expected none", m_even_tlast, m_even_tdata);
                end else begin
                    e_exp = exp_even.pop_front();
                    check("even_beat", 32'({m_even_tlast, m_even_tdata}), 32'(e_exp));
                end
            end
            e_pv = m_even_tvalid;
            e_pr = m_even_tready;
            e_pd = {m_even_tlast, m_even_tdata};
        end
    end

    // Odd-stream monitor.
    logic  o_pv = 1'b0;
    logic  o_pr = 1'b0;
    beat_t o_pd;
    beat_t o_exp;
    always @(negedge a_clk) begin
        if (!axis_aresetn) begin
            o_pv = 1'b0;
        end else begin
            if (o_pv && !o_pr)
                check("odd_stable", 32'({m_odd_tvalid, m_odd_tlast, m_odd_tdata}), 32'({1'b1, o_pd}));
            if (m_odd_tvalid && m_odd_tready) begin
                if (exp_odd.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL odd_unexpected: got last=%b data=%h expected none", m_odd_tlast, m_odd_tdata);
                end else begin
                    o_exp = exp_odd.pop_front();
                    check("odd_beat", 32'({m_odd_tlast, m_odd_tdata}), 32'(o_exp));
                end
            end
            o_pv = m_odd_tvalid;
            o_pr = m_odd_tready;
            o_pd = {m_odd_tlast, m_odd_tdata};
        end
    end

    logic [DATA_W-1:0] odd20 [20] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                      8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19,
                                      8'h1A, 8'h1C, 8'h1F, 8'h23};

    initial begin
        // Reset state
        #2;
        check("reset_outputs", 32'({s_axis_tready, m_even_tvalid, m_even_tlast, m_even_tdata,
                                    m_odd_tvalid, m_odd_tlast, m_odd_tdata}), 32'd0);
        idle(3);
        axis_aresetn = 1'b1;
        idle(2);

        // 1: mixed packet, tready drops for one FLUSH cycle
        push_exp(1'b0, 8'h03, 1'b0);
        push_exp(1'b1, 8'h01, 1'b0);
        push_exp(1'b1, 8'h07, 1'b1);
        push_exp(1'b0, 8'h05, 1'b1);
        send_beat(8'h03, 1'b0);
        send_beat(8'h01, 1'b0);
        send_beat(8'h07, 1'b0);
        send_beat(8'h05, 1'b1);
        @(negedge a_clk);
        check("t1_flush_tready", 32'(s_axis_tready), 32'd0);
        @(negedge a_clk);
        check("t1_run_tready", 32'(s_axis_tready), 32'd1);
        drain();

        // 2: even-only packet; odd stream stays silent
        push_exp(1'b0, 8'h00, 1'b0);
        push_exp(1'b0, 8'h11, 1'b0);
        push_exp(1'b0, 8'h22, 1'b1);
        send_beat(8'h00, 1'b0);
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b1);
        drain();

        // 3: odd back-pressure fills the FIFO after 17 accepted beats
        dir_o_rdy = 1'b0;
        for (int i = 0; i < 20; i++) push_exp(1'b1, odd20[i], i == 19);
        for (int i = 0; i < 17; i++) send_beat(odd20[i], 1'b0);
        s_axis_tdata  = odd20[17];
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge a_clk);
            check("t3_full_tready", 32'(s_axis_tready), 32'd0);
            check("t3_head_held", 32'({m_odd_tvalid, m_odd_tdata}), 32'({1'b1, 8'h01}));
            @(posedge a_clk);
            #1;
        end
        dir_o_rdy = 1'b1;
        send_beat(odd20[17], 1'b0);
        send_beat(odd20[18], 1'b0);
        send_beat(odd20[19], 1'b1);
        drain();

        // 4: single-beat packet appears two cycles after acceptance
        push_exp(1'b1, 8'h80, 1'b1);
        send_beat(8'h80, 1'b1);
        @(negedge a_clk);
        check("t4_not_yet", 32'(m_odd_tvalid), 32'd0);
        @(negedge a_clk);
        check("t4_visible", 32'({m_odd_tvalid, m_odd_tlast, m_odd_tdata}), 32'({1'b1, 1'b1, 8'h80}));
        drain();

        // 5: reset mid-packet discards everything, including a queued entry
        dir_e_rdy = 1'b0;
        dir_o_rdy = 1'b0;
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        @(negedge a_clk);
        check("t5_pre_reset_odd", 32'({m_odd_tvalid, m_odd_tlast, m_odd_tdata}), 32'({1'b1, 1'b0, 8'h01}));
        @(posedge a_clk);
        #1;
        axis_aresetn = 1'b0;
        #1;
        check("t5_reset_outputs", 32'({s_axis_tready, m_even_tvalid, m_even_tlast, m_even_tdata,
                                       m_odd_tvalid, m_odd_tlast, m_odd_tdata}), 32'd0);
        idle(3);
        axis_aresetn = 1'b1;
        dir_e_rdy = 1'b1;
        dir_o_rdy = 1'b1;
        idle(2);
        push_exp(1'b0, 8'h06, 1'b1);
        send_beat(8'h06, 1'b1);
        drain();

        // 6: random soak with toggling consumers
        rand_rdy = 1'b1;
        for (int p = 0; p < 1000; p++) rand_packet();
        rand_rdy = 1'b0;
        drain();

        check("final_queues", 32'(exp_even.size() + exp_odd.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
